// File: rtl/tl_phase_scheduler.sv
// Two-group traffic phase scheduler: G/Y/all-red sequencing from a 1 Hz tick,
// demand-responsive green extension, countdown output and flashing-yellow night mode.
module tl_phase_scheduler #(
  parameter int CNT_W   = 7,
  parameter int G_MIN   = 10,
  parameter int G_MAX   = 30,
  parameter int EXT     = 5,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             night,
  input  logic             req1,
  input  logic             req2,
  output logic             R1,
  output logic             Y1,
  output logic             G1,
  output logic             R2,
  output logic             Y2,
  output logic             G2,
  output logic [CNT_W-1:0] cnt,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    S_NIGHT = 3'd0,
    S_G1    = 3'd1,
    S_Y1    = 3'd2,
    S_AR1   = 3'd3,
    S_G2    = 3'd4,
    S_Y2    = 3'd5,
    S_AR2   = 3'd6,
    S_BAD   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] C_G_MIN = CNT_W'(G_MIN);
  localparam logic [CNT_W-1:0] C_EXT   = CNT_W'(EXT);
  localparam logic [CNT_W-1:0] C_Y     = CNT_W'(Y_TIME);
  localparam logic [CNT_W-1:0] C_AR    = CNT_W'(AR_TIME);
  localparam logic [CNT_W:0]   C_G_MAX = (CNT_W+1)'(G_MAX);

  // Lamp vector order: {R1, Y1, G1, R2, Y2, G2}
  localparam logic [5:0] L_RESET = 6'b100100;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] gel, gel_n, gel_inc;
  logic [CNT_W:0]   ext_sum;
  logic             dem1, dem2, dem1_n, dem2_n;
  logic             flash, flash_n;
  logic             opp_dem;
  logic             is_green;
  logic [5:0]       lamps, lamps_n;

  assign is_green = (state == S_G1) || (state == S_G2);
  assign opp_dem  = (state == S_G1) ? dem2 : dem1;
  assign gel_inc  = gel + CNT_W'(1);
  assign ext_sum  = {1'b0, gel_inc} + {1'b0, C_EXT};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_n = state;
    cnt_n   = cnt;
    gel_n   = gel;
    flash_n = flash;
    if (night) begin
      state_n = S_NIGHT;
      cnt_n   = '0;
      gel_n   = '0;
      flash_n = (state == S_NIGHT) & (flash ^ tick_1s);
    end else if (state == S_NIGHT || state == S_BAD) begin
      state_n = S_AR2;
      cnt_n   = C_AR;
      gel_n   = '0;
      flash_n = 1'b0;
    end else if (tick_1s) begin
      if (is_green) gel_n = gel_inc;
      if (cnt > CNT_W'(1)) begin
        cnt_n = cnt - CNT_W'(1);
      end else begin
        unique case (state)
          S_G1, S_G2: begin
            if (!opp_dem && ext_sum <= C_G_MAX) begin
              cnt_n = C_EXT;
            end else begin
              state_n = (state == S_G1) ? S_Y1 : S_Y2;
              cnt_n   = C_Y;
            end
          end
          S_Y1:  begin state_n = S_AR1; cnt_n = C_AR; end
          S_Y2:  begin state_n = S_AR2; cnt_n = C_AR; end
          S_AR1: begin state_n = S_G2;  cnt_n = C_G_MIN; gel_n = '0; end
          S_AR2: begin state_n = S_G1;  cnt_n = C_G_MIN; gel_n = '0; end
          default: ;
        endcase
      end
    end
  end

  // Demand set wins over the clear that happens on entry to the served green.
  always_comb begin
    dem1_n = req1 | (dem1 & ~(state_n == S_G1 && state != S_G1));
    dem2_n = req2 | (dem2 & ~(state_n == S_G2 && state != S_G2));
    if (state == S_NIGHT) begin
      dem1_n = 1'b0;
      dem2_n = 1'b0;
    end
  end

  // Lamps decode the next state so they land on the same edge as phase.
  always_comb begin
    lamps_n = L_RESET;
    unique case (state_n)
      S_NIGHT: lamps_n = {1'b0, flash_n, 1'b0, 1'b0, flash_n, 1'b0};
      S_G1:    lamps_n = 6'b001100;
      S_Y1:    lamps_n = 6'b010100;
      S_G2:    lamps_n = 6'b100001;
      S_Y2:    lamps_n = 6'b100010;
      default: lamps_n = L_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_AR2;
      cnt   <= C_AR;
      gel   <= '0;
      dem1  <= 1'b0;
      dem2  <= 1'b0;
      flash <= 1'b0;
      lamps <= L_RESET;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_n;
      cnt   <= cnt_n;
      gel   <= gel_n;
      dem1  <= dem1_n;
      dem2  <= dem2_n;
      flash <= flash_n;
      lamps <= lamps_n;
    end
  end

  assign {R1, Y1, G1, R2, Y2, G2} = lamps;
  assign phase = state;

endmodule
